even_parity_tx: RTL

EVEN_PARITY_TX -- requirements
Module: even_parity_tx

---
 rtl/even_parity_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/even_parity_tx.sv
// Purpose : serial transmitter framing a DATA_BITS word as start(0), data MSB first,
//           even-parity bit P, stop(1); each serial bit lasts BIT_CYCLES clocks.
// Latency : start bit on tx_out the cycle after the accepting edge; frame is
//           (DATA_BITS+3)*BIT_CYCLES cycles, frame_done marks its last cycle.
// Backpressure: ready=~busy; a load while busy is ignored with no side effects.
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   reset      - synchronous active-high reset
//   data_in    - word to send, data_in[DATA_BITS-1] goes out first
//   load       - transmit request, accepted when ready=1
//   ready      - high when a load will be accepted
//   tx_out     - registered serial line, idle high
//   busy       - high while a frame is in progress
//   par_out    - even-parity bit of the most recently accepted word
//   frame_done - one-cycle pulse on the last cycle of the stop bit
module even_parity_tx #(
  parameter int DATA_BITS  = 3,
  parameter int BIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 par_out,
  output logic                 frame_done
);

  // Counter widths come from the parameters so they never wrap inside a frame.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int DW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   bit_last;

  // Last cycle of the current serial bit.
  assign bit_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        dcnt_d = '0;
        if (load) begin
          shift_d = data_in;
          par_d   = ^data_in;
          state_d = START;
        end
      end
      START: begin
        if (bit_last) begin
          dcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_last) begin
          // Shifting left exposes the next data bit at the MSB.
          shift_d = shift_q << 1;
          if (dcnt_q == DCNT_LAST) begin
            state_d = PARITY;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_last) state_d = STOP;
      end
      STOP: begin
        if (bit_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      cnt_d = bit_last ? '0 : cnt_q + CW'(1);
    end

    // Line level is computed from the next state so tx_out is a pure flop
    // and lines up with the state it represents.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[DATA_BITS-1];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign ready      = ~busy;
  assign tx_out     = tx_q;
  assign par_out    = par_q;
  assign frame_done = (state_q == STOP) && bit_last;

endmodule
